bus_initiator_8088: RTL and testbench

BUS_INITIATOR_8088 -- requirements
Module: bus_initiator_8088

---
 rtl/bus_initiator_8088.sv | 141 ++++++++++++++
 tb/tb_bus_initiator_8088.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_initiator_8088.sv
// 8088-style minimum-mode bus initiator: each accepted host request runs one T1..T4 bus cycle.
// Optional HOLD/HLDA arbitration is compiled in when HOLD_ARB_EN is defined.
module bus_initiator_8088 (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  input  logic        we,
  input  logic        io,
  input  logic [19:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        ack,
  output logic [7:0]  rdata,
  inout  wire  [7:0]  AD,
  output logic [11:0] A,
  output logic        ALE,
  output logic        RD,
  output logic        WR,
  output logic        IOM,
  output logic        DTR,
  output logic        DEN,
  input  logic        READY,
  input  logic        HOLD,
  output logic        HLDA
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4
`ifdef HOLD_ARB_EN
    , S_HLD
`endif
  } state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        we_q, io_q;
  logic [19:0] addr_q;
  logic [7:0]  wdata_q;
  logic        ad_oe;
  logic [7:0]  ad_out;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE, S_T4: begin
`ifdef HOLD_ARB_EN
        if (HOLD) state_nxt = S_HLD;
        else
`endif
        if (req) begin
          state_nxt = S_T1;
          accept    = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_T1:       state_nxt = S_T2;
      S_T2:       state_nxt = S_T3;
      S_T3, S_TW: state_nxt = READY ? S_T4 : S_TW;
`ifdef HOLD_ARB_EN
      S_HLD:      if (!HOLD) state_nxt = S_IDLE;
`endif
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= we;
        io_q    <= io;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      // AD is sampled while RD is still low on the edge that ends the data phase
      if ((state == S_T3 || state == S_TW) && READY && !we_q)
        rdata <= AD;
    end
  end

  always_comb begin
    ALE    = 1'b0;
    RD     = 1'b1;
    WR     = 1'b1;
    DEN    = 1'b1;
    A      = '0;
    IOM    = 1'b0;
    DTR    = 1'b0;
    ad_oe  = 1'b0;
    ad_out = wdata_q;
    case (state)
      S_T1: begin
        ALE    = 1'b1;
        A      = addr_q[19:8];
        IOM    = io_q;
        DTR    = we_q;
        ad_oe  = 1'b1;
        ad_out = addr_q[7:0];
      end
      S_T2, S_T3, S_TW: begin
        A     = addr_q[19:8];
        IOM   = io_q;
        DTR   = we_q;
        DEN   = 1'b0;
        RD    = we_q;
        WR    = ~we_q;
        ad_oe = we_q;
      end
      S_T4: begin
        A     = addr_q[19:8];
        IOM   = io_q;
        DTR   = we_q;
        ad_oe = we_q;
      end
      default: ;
    endcase
  end

  assign AD   = ad_oe ? ad_out : 8'hzz;
  assign busy = (state != S_IDLE);
  assign ack  = (state == S_T4);

`ifdef HOLD_ARB_EN
  assign HLDA = (state == S_HLD);
`else
  // HOLD has no effect in this build
  logic unused_hold;
  assign unused_hold = HOLD;
  assign HLDA = 1'b0;
`endif

endmodule

// File: tb/tb_bus_initiator_8088.sv
// Randomized bus-cycle bench for bus_initiator_8088 against a phase-indexed transaction model.
// Define HOLD_ARB_EN to also exercise the HOLD/HLDA handover.
module tb_bus_initiator_8088;

  logic        CLK = 1'b0;
  logic        RESET, req, we, io, READY, HOLD;
  logic [19:0] addr;
  logic [7:0]  wdata, rdata, resp_data;
  logic        busy, ack, ALE, RD, WR, IOM, DTR, DEN, HLDA;
  logic [11:0] A;
  wire  [7:0]  AD;

  // Responder drives the bus only while the read strobe is asserted
  assign AD = (RD === 1'b0) ? resp_data : 8'hzz;

  bus_initiator_8088 dut (
    .CLK(CLK), .RESET(RESET), .req(req), .we(we), .io(io), .addr(addr),
    .wdata(wdata), .busy(busy), .ack(ack), .rdata(rdata), .AD(AD), .A(A),
    .ALE(ALE), .RD(RD), .WR(WR), .IOM(IOM), .DTR(DTR), .DEN(DEN),
    .READY(READY), .HOLD(HOLD), .HLDA(HLDA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        w;
    logic        i;
    logic [19:0] a;
    logic [7:0]  d;
    logic [7:0]  rv;
    int unsigned waits;
    logic        chain;
  } txn_t;

  int unsigned checks = 0;
  int unsigned fails  = 0;
  logic [7:0]  exp_rdata = 8'h00;
  txn_t        q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic w, input logic i, input logic [19:0] a,
                              input logic [7:0] d, input logic [7:0] rv,
                              input int unsigned waits, input logic chain);
    txn_t t;
    t.w = w; t.i = i; t.a = a; t.d = d; t.rv = rv; t.waits = waits; t.chain = chain;
    return t;
  endfunction

  task automatic present(input txn_t t);
    req = 1'b1; we = t.w; io = t.i; addr = t.a; wdata = t.d;
  endtask

  // {ALE,RD,WR,DEN,ack,busy,HLDA} when no bus cycle is running
  task automatic check_idle(input string tag);
    logic [7:0] z = 8'hzz;
    check_eq({tag, "_ctl"}, {ALE, RD, WR, DEN, ack, busy, HLDA}, 7'b0111000);
    check_eq({tag, "_ad"}, AD, z);
    check_eq({tag, "_rdata"}, rdata, exp_rdata);
  endtask

  // Phase k counts clocks since acceptance: 0 = address, last = 3+waits = ack, between = data strobe.
  task automatic run_txn(input txn_t t, input txn_t nt);
    int unsigned last = 3 + t.waits;
    logic [7:0]  z = 8'hzz;
    resp_data = t.rv;
    for (int unsigned k = 0; k <= last; k++) begin
      @(negedge CLK);
      check_eq("hi_fields", {A, IOM, DTR}, {t.a[19:8], t.i, t.w});
      if (k == 0) begin
        check_eq("t1_ctl", {ALE, RD, WR, DEN, ack, busy, HLDA}, 7'b1111010);
        check_eq("t1_ad", AD, t.a[7:0]);
      end else if (k < last) begin
        check_eq("data_ctl", {ALE, RD, WR, DEN, ack, busy, HLDA}, {1'b0, t.w, ~t.w, 4'b0010});
        check_eq("data_ad", AD, t.w ? t.d : t.rv);
      end else begin
        if (!t.w) exp_rdata = t.rv;
        check_eq("t4_ctl", {ALE, RD, WR, DEN, ack, busy, HLDA}, 7'b0111110);
        check_eq("t4_ad", AD, t.w ? t.d : z);
        check_eq("t4_rdata", rdata, exp_rdata);
      end
      READY = (k >= 2) ? ((k - 2 < t.waits) ? 1'b0 : 1'b1) : 1'($urandom);
      if (k < last) begin
        req = 1'($urandom); we = 1'($urandom); io = 1'($urandom);
        addr = 20'($urandom); wdata = 8'($urandom);
`ifndef HOLD_ARB_EN
        HOLD = 1'($urandom);
`endif
      end else if (t.chain) begin
        present(nt);
      end else begin
        req = 1'b0;
      end
      @(posedge CLK);
    end
  endtask

  task automatic run_list();
    for (int n = 0; n < q.size(); n++) begin
      if (n == q.size() - 1) q[n].chain = 1'b0;
      if (n == 0 || !q[n-1].chain) begin
        @(negedge CLK);
        check_idle("idle");
        present(q[n]);
        @(posedge CLK);
      end
      run_txn(q[n], q[(n + 1 < q.size()) ? n + 1 : n]);
    end
    q.delete();
  endtask

  initial begin
    logic [7:0] z = 8'hzz;
    txn_t t, t2;
    RESET = 1'b1; req = 1'b0; we = 1'b0; io = 1'b0; addr = '0; wdata = '0;
    READY = 1'b1; HOLD = 1'b0; resp_data = 8'h00;
    #1;
    check_eq("rst_ctl", {ALE, RD, WR, DEN, IOM, DTR, ack, busy, HLDA}, 9'b011100000);
    check_eq("rst_a", A, 12'h000);
    check_eq("rst_ad", AD, z);
    check_eq("rst_rdata", rdata, 8'h00);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;

    // Directed cycles, then random ones with chained and isolated requests
    q.push_back(mk(1'b0, 1'b0, 20'h81234, 8'h00, 8'h5A, 0, 1'b0));
    q.push_back(mk(1'b1, 1'b1, 20'h08001, 8'hC3, 8'h00, 3, 1'b0));
    q.push_back(mk(1'b0, 1'b0, 20'h00010, 8'h00, 8'hA7, 0, 1'b1));
    q.push_back(mk(1'b0, 1'b0, 20'h00011, 8'h00, 8'h3C, 0, 1'b0));
    for (int n = 0; n < 40; n++)
      q.push_back(mk(1'($urandom), 1'($urandom), 20'($urandom), 8'($urandom),
                     8'($urandom), $urandom_range(0, 4), 1'($urandom)));
    run_list();

    // Reset in the middle of a write wait state aborts the cycle
    @(negedge CLK);
    check_idle("pre_rst");
    present(mk(1'b1, 1'b1, 20'hABCDE, 8'h96, 8'h00, 5, 1'b0));
    READY = 1'b0;
    repeat (4) begin
      @(posedge CLK);
      @(negedge CLK);
      req = 1'b0;
    end
    check_eq("tw_wr", {WR, DEN}, 2'b00);
    #2 RESET = 1'b1;
    #1;
    exp_rdata = 8'h00;
    check_eq("abort_ctl", {ALE, RD, WR, DEN, IOM, DTR, ack, busy, HLDA}, 9'b011100000);
    check_eq("abort_a", A, 12'h000);
    check_eq("abort_ad", AD, z);
    check_eq("abort_rdata", rdata, 8'h00);
    repeat (2) begin
      @(negedge CLK);
      check_eq("rst_noack", ack, 1'b0);
    end
    RESET = 1'b0;
    READY = 1'b1;
    q.push_back(mk(1'b0, 1'b0, 20'h12345, 8'h00, 8'hE1, 1, 1'b0));
    run_list();

`ifdef HOLD_ARB_EN
    // HOLD raised during a read with a request pending: read finishes, bus handed over, then T1
    t  = mk(1'b0, 1'b0, 20'h44444, 8'h00, 8'h19, 0, 1'b1);
    t2 = mk(1'b1, 1'b0, 20'h55555, 8'h6E, 8'h00, 0, 1'b0);
    @(negedge CLK);
    check_idle("hold_pre");
    present(t);
    @(posedge CLK);
    HOLD = 1'b1;
    run_txn(t, t2);
    for (int n = 0; n < 3; n++) begin
      @(negedge CLK);
      check_eq("hld_ctl", {ALE, RD, WR, DEN, ack, busy, HLDA}, 7'b0111011);
      check_eq("hld_ad", AD, z);
    end
    HOLD = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check_idle("hold_rel");
    @(posedge CLK);
    run_txn(t2, t2);
`else
    t  = mk(1'b0, 1'b1, 20'h44444, 8'h00, 8'h19, 0, 1'b0);
    t2 = t;
    @(negedge CLK);
    HOLD = 1'b1;
    check_idle("nohold_pre");
    present(t);
    @(posedge CLK);
    run_txn(t, t2);
    HOLD = 1'b0;
`endif

    @(negedge CLK);
    check_idle("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
